// File: rtl/puf_cali_pkg.sv
// Shared types for the PUF response calibrator: FSM encoding,
// constant clog2 helper and default counter width.
package puf_cali_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FIRE   = 3'd1,
    S_WAIT   = 3'd2,
    S_DECIDE = 3'd3,
    S_DONE   = 3'd4
  } cali_state_t;

  function automatic int cali_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  localparam int DEF_NUM_EVAL = 15;
  localparam int CNT_W = cali_clog2(DEF_NUM_EVAL + 1);

endpackage

// File: rtl/puf_resp_calibrator_if.sv
// Calibrator bus: run control (start/busy/done/err), latch-array
// race handshake (eval_req/eval_vld/eval_bits) and result vectors.
// slave = calibrator side, master = controller / latch array side.
interface puf_resp_calibrator_if #(
  parameter int NUM_CH = 8
);
  logic              start;
  logic              busy;
  logic              eval_req;
  logic              eval_vld;
  logic [NUM_CH-1:0] eval_bits;
  logic [NUM_CH-1:0] resp;
  logic [NUM_CH-1:0] stable_mask;
  logic              done;
  logic              err;

  modport slave (
    input  start, eval_vld, eval_bits,
    output busy, eval_req, resp, stable_mask, done, err
  );

  modport master (
    output start, eval_vld, eval_bits,
    input  busy, eval_req, resp, stable_mask, done, err
  );
endinterface

// File: rtl/cali_ch_counter.sv
// One response channel: counts ones over a run, then registers the
// majority vote and stability flag. Ports: clk, rst, clr, acc, race,
// decide, wipe -> resp, stable.
import puf_cali_pkg::*;

module cali_ch_counter #(
  parameter int NUM_EVAL = DEF_NUM_EVAL,
  parameter int MARGIN   = 2,
  parameter int CW       = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic acc,
  input  logic race,
  input  logic decide,
  input  logic wipe,
  output logic resp,
  output logic stable
);

  localparam logic [CW-1:0] HALF = CW'(NUM_EVAL / 2);
  localparam logic [CW-1:0] LO   = CW'(MARGIN);
  localparam logic [CW-1:0] HI   = CW'(NUM_EVAL - MARGIN);

  logic [CW-1:0] ones;
  logic          maj;
  logic          stab;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ones <= '0;
    else if (clr)
      ones <= '0;
    else if (acc && race)
      ones <= ones + 1'b1;
  end

  assign maj  = ones > HALF;
  assign stab = (ones <= LO) || (ones >= HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp   <= 1'b0;
      stable <= 1'b0;
    end else if (wipe) begin
      resp   <= 1'b0;
      stable <= 1'b0;
    end else if (decide) begin
      resp   <= maj;
      stable <= stab;
    end
  end

endmodule

// File: rtl/puf_resp_calibrator.sv
// Multi-channel PUF response calibrator: fires NUM_EVAL races per run
// and reports majority response plus stability mask over bus (slave).
// Ports: clk, rst (async, active-high), bus. Optional watchdog on the
// WAIT state is enabled by defining PUF_CALI_TIMEOUT_EN.
import puf_cali_pkg::*;

module puf_resp_calibrator #(
  parameter int NUM_CH        = 8,
  parameter int NUM_EVAL      = DEF_NUM_EVAL,
  parameter int STABLE_MARGIN = 2,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  puf_resp_calibrator_if.slave  bus
);

  localparam int CW = cali_clog2(NUM_EVAL + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_EVAL - 1);

  if (NUM_CH < 1 || NUM_CH > 64 ||
      NUM_EVAL < 1 || NUM_EVAL > 255 ||
      (NUM_EVAL % 2) == 0 ||
      2 * STABLE_MARGIN >= NUM_EVAL ||
      TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("puf_resp_calibrator: bad parameters");
  end

  cali_state_t state;
  cali_state_t nxt;

  logic [CW-1:0]     eval_cnt;
  logic              req_q;
  logic              done_q;
  logic              take;
  logic              clr;
  logic              decide;
  logic              tmo;
  logic [NUM_CH-1:0] resp_v;
  logic [NUM_CH-1:0] stab_v;

  assign take   = (state == S_WAIT) && bus.eval_vld;
  assign clr    = (state == S_IDLE) && bus.start;
  assign decide = (state == S_DECIDE);

`ifdef PUF_CALI_TIMEOUT_EN
  localparam int WW = cali_clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] wcnt;
  logic          err_q;

  // Held at zero outside WAIT, so every WAIT entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wcnt <= '0;
    else if (state != S_WAIT)
      wcnt <= '0;
    else if (!bus.eval_vld)
      wcnt <= wcnt + 1'b1;
  end

  assign tmo = (state == S_WAIT) && !bus.eval_vld &&
               (wcnt == WLIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (clr)
      err_q <= 1'b0;
    else if (tmo)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign tmo     = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (bus.start) nxt = S_FIRE;
      S_FIRE:   nxt = S_WAIT;
      S_WAIT: begin
        if (take)
          nxt = (eval_cnt == LAST) ? S_DECIDE : S_FIRE;
        else if (tmo)
          nxt = S_DONE;
      end
      S_DECIDE: nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      eval_cnt <= '0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= nxt;
      req_q  <= (nxt == S_FIRE);
      done_q <= (nxt == S_DONE);
      if (clr)
        eval_cnt <= '0;
      else if (take)
        eval_cnt <= eval_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cali_ch_counter #(
      .NUM_EVAL (NUM_EVAL),
      .MARGIN   (STABLE_MARGIN),
      .CW       (CW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .acc    (take),
      .race   (bus.eval_bits[i]),
      .decide (decide),
      .wipe   (tmo),
      .resp   (resp_v[i]),
      .stable (stab_v[i])
    );
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.eval_req    = req_q;
  assign bus.done        = done_q;
  assign bus.resp        = resp_v;
  assign bus.stable_mask = stab_v;

endmodule

// File: tb/tb_puf_resp_calibrator.sv
// Bench for puf_resp_calibrator: randomized latch-array responder,
// run-level reference model and a per-cycle compare process.
module tb_puf_resp_calibrator;

  localparam int NCH = 8;
  localparam int NEV = 15;
  localparam int MRG = 2;
  localparam int TMO = 64;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puf_resp_calibrator_if #(.NUM_CH(NCH)) bus ();
  puf_resp_calibrator_if #(.NUM_CH(NCH)) bus6 ();

  puf_resp_calibrator #(
    .NUM_CH(NCH), .NUM_EVAL(NEV),
    .STABLE_MARGIN(MRG), .TIMEOUT_CYC(TMO)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  puf_resp_calibrator #(
    .NUM_CH(NCH), .NUM_EVAL(1),
    .STABLE_MARGIN(0), .TIMEOUT_CYC(TMO)
  ) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // model state
  int ones [NCH];
  int n_req, extra, req_seen;
  int run_t0, done_due, err_clr_at;
  bit run_on, tmo_run, err_exp, chk_en;
  logic [NCH-1:0] hold_resp, hold_mask;

  // responder config
  bit resp_en, glitch_en;
  int dly_max, mode;
  int thr [NCH];

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NCH-1:0] gen_bits(int idx);
    logic [NCH-1:0] b;
    b = '0;
    case (mode)
      1: b = '1;
      2: begin
        b[0] = (idx % 2 == 0);
        b[1] = (idx != 14);
      end
      default:
        for (int c = 0; c < NCH; c++)
          b[c] = ($urandom_range(0, 15) < thr[c]);
    endcase
    return b;
  endfunction

  task automatic model_clear();
    foreach (ones[c]) ones[c] = 0;
    n_req = 0; extra = 0; req_seen = 0;
    done_due = BIG; tmo_run = 0;
  endtask

  task automatic model_reset();
    model_clear();
    run_on = 0; err_exp = 0;
    hold_resp = '0; hold_mask = '0;
    err_clr_at = -1;
  endtask

  // latch-array emulator
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && bus.eval_req && !rst) begin
        int d;
        logic [NCH-1:0] b;
        d = $urandom_range(0, dly_max);
        b = gen_bits(n_req);
        if (glitch_en && $urandom_range(0, 1) == 1) begin
          bus.eval_vld  = 1'b1;
          bus.eval_bits = NCH'($urandom);
        end
        @(posedge clk); #1;
        bus.eval_vld = 1'b0;
        repeat (d) begin @(posedge clk); #1; end
        bus.eval_bits = b;
        bus.eval_vld  = 1'b1;
        for (int c = 0; c < NCH; c++) ones[c] += int'(b[c]);
        n_req++;
        extra += d;
        if (n_req == NEV) done_due = cyc + 2;
        @(posedge clk); #1;
        bus.eval_vld  = 1'b0;
        bus.eval_bits = NCH'($urandom);
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && chk_en) begin
        bit e_done, e_busy;
        e_done = run_on && (cyc == done_due);
        e_busy = run_on && (cyc > run_t0) &&
                 (cyc <= done_due);
        if (cyc == err_clr_at) err_exp = 0;
        if (bus.eval_req) req_seen++;
        if (e_done) begin
          if (tmo_run) begin
            hold_resp = '0;
            hold_mask = '0;
            err_exp   = 1;
          end else begin
            for (int c = 0; c < NCH; c++) begin
              hold_resp[c] = ones[c] > NEV / 2;
              hold_mask[c] = (ones[c] <= MRG) ||
                             (ones[c] >= NEV - MRG);
            end
            chk("req_count", req_seen, NEV);
          end
        end
        chk("busy", bus.busy, e_busy);
        chk("done", bus.done, e_done);
        chk("err", bus.err, err_exp);
        chk("resp", bus.resp, hold_resp);
        chk("mask", bus.stable_mask, hold_mask);
        if (!e_busy) chk("req_idle", bus.eval_req, 0);
        if (e_done) run_on = 0;
      end
    end
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while (bus.busy && w < 500) begin
      @(negedge clk); w++;
    end
    if (bus.busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic kick();
    @(posedge clk); #1;
    bus.start  = 1'b1;
    run_t0     = cyc;
    err_clr_at = cyc + 1;
    run_on     = 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_one(int md, output int lat);
    int w;
    wait_idle();
    model_clear();
    mode = md;
    lat  = -1;
    kick();
    w = 0;
    while (w < 2000) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - run_t0 + 1;
        break;
      end
      w++;
    end
    if (lat < 0) chk("run_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_req(output int c);
    int w;
    c = -1;
    w = 0;
    while (w < 200) begin
      @(negedge clk);
      if (bus.eval_req) begin
        c = cyc;
        break;
      end
      w++;
    end
    if (c < 0) chk("req_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_req", bus.eval_req, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_resp", bus.resp, 0);
    chk("rst_mask", bus.stable_mask, 0);
    model_reset();
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    int lat, c, w, t6;
    int opts [5];
    opts = '{0, 1, 8, 15, 16};
    rst = 1'b1;
    bus.start = 0; bus.eval_vld = 0; bus.eval_bits = '0;
    bus6.start = 0; bus6.eval_vld = 0; bus6.eval_bits = '0;
    resp_en = 1; glitch_en = 0; dly_max = 0; mode = 1;
    chk_en = 0;
    foreach (thr[i]) thr[i] = 8;
    model_reset();

    #12;
    chk("reset_busy", bus.busy, 0);
    chk("reset_req", bus.eval_req, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_resp", bus.resp, 0);
    chk("reset_mask", bus.stable_mask, 0);
    #10;
    rst = 1'b0;
    chk_en = 1;

    // all ones, immediate replies
    run_one(1, lat);
    chk("t1_lat", lat, 33);
    chk("t1_resp", bus.resp, 8'hFF);
    chk("t1_mask", bus.stable_mask, 8'hFF);

    // ch0 8/15, ch1 14/15
    run_one(2, lat);
    chk("t2_lat", lat, 33);
    chk("t2_model", hold_resp, 8'h03);
    chk("t2_resp", bus.resp, 8'h03);
    chk("t2_mask", bus.stable_mask, 8'hFE);

    // stray vld in IDLE, glitches in FIRE, start mid-run
    @(posedge clk); #1;
    bus.eval_vld = 1; bus.eval_bits = '1;
    @(posedge clk); #1;
    bus.eval_vld = 0;
    glitch_en = 1;
    fork
      run_one(2, lat);
      begin
        w = 0;
        while (n_req < 5 && w < 200) begin
          @(negedge clk); w++;
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    join
    chk("t3_reqs", req_seen, 15);
    chk("t3_resp", bus.resp, 8'h03);
    chk("t3_mask", bus.stable_mask, 8'hFE);
    chk("t3_lat", lat, 33);

    // randomized runs
    dly_max = 3;
    for (int r = 0; r < 10; r++) begin
      foreach (thr[i]) thr[i] = opts[$urandom_range(0, 4)];
      run_one(0, lat);
      chk("rnd_lat", lat, 2 * NEV + 3 + extra);
    end
    glitch_en = 0;
    dly_max = 0;

    // reset in WAIT after 7 evals
    run_one(1, lat);
    wait_idle();
    model_clear();
    mode = 0;
    foreach (thr[i]) thr[i] = 8;
    kick();
    w = 0;
    while (n_req < 7 && w < 200) begin
      @(negedge clk); w++;
    end
    resp_en = 0;
    wait_req(c);
    @(negedge clk);
    do_reset();
    resp_en = 1;
    run_one(1, lat);
    chk("t4_lat", lat, 33);
    chk("t4_reqs", req_seen, 15);
    chk("t4_resp", bus.resp, 8'hFF);
    chk("t4_mask", bus.stable_mask, 8'hFF);

    // watchdog
    wait_idle();
    model_clear();
    resp_en = 0;
    kick();
    wait_req(c);
`ifdef PUF_CALI_TIMEOUT_EN
    tmo_run  = 1;
    done_due = c + TMO + 1;
    lat = -1;
    w = 0;
    while (w < 300) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - c;
        break;
      end
      w++;
    end
    chk("t5_tmo_lat", lat, TMO + 1);
    chk("t5_err", bus.err, 1);
    chk("t5_resp", bus.resp, 0);
    chk("t5_mask", bus.stable_mask, 0);
    resp_en = 1;
    run_one(1, lat);
    chk("t5_err_clr", bus.err, 0);
`else
    repeat (TMO + 16) @(negedge clk);
    chk("t5_busy_hold", bus.busy, 1);
    chk("t5_no_err", bus.err, 0);
    do_reset();
    resp_en = 1;
`endif

    // single-evaluation instance
    @(posedge clk); #1;
    bus6.start = 1'b1;
    t6 = cyc;
    @(posedge clk); #1;
    bus6.start = 1'b0;
    w = 0;
    while (!bus6.eval_req && w < 50) begin
      @(negedge clk); w++;
    end
    chk("t6_req", bus6.eval_req, 1);
    @(posedge clk); #1;
    bus6.eval_vld = 1'b1;
    bus6.eval_bits = 8'hA5;
    @(posedge clk); #1;
    bus6.eval_vld = 1'b0;
    bus6.eval_bits = '0;
    lat = -1;
    w = 0;
    while (w < 50) begin
      @(negedge clk);
      if (bus6.done) begin
        lat = cyc - t6 + 1;
        break;
      end
      w++;
    end
    chk("t6_lat", lat, 5);
    chk("t6_resp", bus6.resp, 8'hA5);
    chk("t6_mask", bus6.stable_mask, 8'hFF);
    @(negedge clk);
    chk("t6_idle", bus6.busy, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
